// File: rtl/cpld_scan_ctrl_if.sv
// Bundle of the scan handshake, the CPLD3 datapath hooks and the result bus.
// slave  : the controller's view
// master : the row source / datapath / result consumer view
interface cpld_scan_ctrl_if;
  // scan control
  logic       start;
  logic       abort;
  logic [2:0] max_row;
  // row source handshake
  logic [4:0] row_data;
  logic       row_valid;
  logic       row_ready;
  // CPLD3 datapath drive and return
  logic [4:0] left_in2;
  logic [2:0] sel;
  logic [2:0] pos_c;
  logic [3:0] sel_out2;
  logic [4:0] right_out2;
  logic       last_row;
  // captured results and status
  logic [4:0] res_data;
  logic [3:0] res_sel;
  logic [2:0] res_pos;
  logic       res_valid;
  logic       busy;
  logic       done;

  modport slave (
    input  start, abort, max_row, row_data, row_valid,
           sel_out2, right_out2, last_row,
    output row_ready, left_in2, sel, pos_c,
           res_data, res_sel, res_pos, res_valid, busy, done
  );

  modport master (
    output start, abort, max_row, row_data, row_valid,
           sel_out2, right_out2, last_row,
    input  row_ready, left_in2, sel, pos_c,
           res_data, res_sel, res_pos, res_valid, busy, done
  );
endinterface

// File: rtl/cpld_scan_ctrl.sv
// Row-scan controller for the CPLD3 datapath.
// Fetches one row word per step, waits one cycle for the datapath to settle,
// captures its result, and walks pos_c from 0 up to the latched limit (or an
// early last_row). sel cycles modulo 5 alongside pos_c.
module cpld_scan_ctrl (
  input  logic              clk,
  input  logic              rst,
  cpld_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_SETTLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t     r_state;
  logic [2:0] r_lim;
  logic [2:0] r_pos;
  logic [2:0] r_sel;
  logic [4:0] r_left;
  logic [4:0] r_res_data;
  logic [3:0] r_res_sel;
  logic [2:0] r_res_pos;
  logic       r_res_valid;
  logic       r_busy;
  logic       r_done;

  // Scan ends on the datapath's flag or when the latched limit is reached;
  // lim <= 7 means pos_c can never need to wrap.
  logic       w_last;
  logic [2:0] w_sel_nxt;
  assign w_last    = bus.last_row || (r_pos == r_lim);
  assign w_sel_nxt = (r_sel == 3'd4) ? 3'd0 : (r_sel + 3'd1);

  // Main FSM; every output except row_ready is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_lim       <= 3'd0;
      r_pos       <= 3'd0;
      r_sel       <= 3'd0;
      r_left      <= 5'd0;
      r_res_data  <= 5'd0;
      r_res_sel   <= 4'd0;
      r_res_pos   <= 3'd0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      // pulses default low; only the capture / FIN-entry edges raise them
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort is not looked at here, so start+abort still starts a scan
          if (bus.start) begin
            r_lim   <= bus.max_row;
            r_pos   <= 3'd0;
            r_sel   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (bus.row_valid) begin
            r_left  <= bus.row_data;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // abort wins over the capture: the row in flight is dropped silently
          if (bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_res_data  <= bus.right_out2;
            r_res_sel   <= bus.sel_out2;
            r_res_pos   <= r_pos;
            r_res_valid <= 1'b1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_pos   <= r_pos + 3'd1;
              r_sel   <= w_sel_nxt;
              r_state <= S_FETCH;
            end
          end
        end
        S_FIN: begin
          // done is already high for this one cycle; abort has no effect here
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.row_ready = (r_state == S_FETCH);
  assign bus.left_in2  = r_left;
  assign bus.sel       = r_sel;
  assign bus.pos_c     = r_pos;
  assign bus.res_data  = r_res_data;
  assign bus.res_sel   = r_res_sel;
  assign bus.res_pos   = r_res_pos;
  assign bus.res_valid = r_res_valid;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_cpld_scan_ctrl.sv
// Directed bench for cpld_scan_ctrl. A small row source (row_data = base + pos_c)
// and a combinational stand-in for CPLD3 (right_out2 = left_in2 ^ 5'h1F,
// sel_out2 = {1'b1, sel}) feed the controller. Inputs change and checks are made
// on the falling edge; a posedge monitor logs every result and done pulse.
module tb_cpld_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpld_scan_ctrl_if bus ();

  cpld_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [4:0] rd_base;
  logic       lr_en;
  logic [2:0] lr_pos;

  // row source and datapath stand-in
  always_comb begin
    bus.row_data   = rd_base + {2'b00, bus.pos_c};
    bus.right_out2 = bus.left_in2 ^ 5'h1F;
    bus.sel_out2   = {1'b1, bus.sel};
    bus.last_row   = lr_en && (bus.pos_c == lr_pos);
  end

  // result log (never cleared; tests index from their own starting point)
  logic [4:0] cap_data[$];
  logic [3:0] cap_sel[$];
  logic [2:0] cap_pos[$];
  int         cap_cyc[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  int         bad_sel  = 0;
  int         cyc      = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.res_valid === 1'b1) begin
      cap_data.push_back(bus.res_data);
      cap_sel.push_back(bus.res_sel);
      cap_pos.push_back(bus.res_pos);
      cap_cyc.push_back(cyc);
    end
    if (bus.done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (bus.sel > 3'd4) bad_sel = bad_sel + 1;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_scan(input logic [2:0] m);
    bus.max_row = m;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  // runs until busy drops; reports the largest pos_c seen on the way
  task automatic wait_idle(input int lim, output bit ok, output int maxp);
    ok   = 1'b0;
    maxp = 0;
    for (int i = 0; i < lim; i++) begin
      if (bus.busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      if (int'(bus.pos_c) > maxp) maxp = int'(bus.pos_c);
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b1; bus.abort = 1'b0; bus.max_row = 3'd3; bus.row_valid = 1'b0;
    rd_base = 5'd0; lr_en = 1'b0; lr_pos = 3'd0;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.done, bus.res_valid, bus.row_ready} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
                         {bus.busy, bus.done, bus.res_valid, bus.row_ready});
    end
    checks++;
    if ({bus.left_in2, bus.pos_c, bus.sel, bus.res_data, bus.res_sel, bus.res_pos} !== 23'd0) begin
      errors++; $display("FAIL reset_regs: got %h want 0",
                         {bus.left_in2, bus.pos_c, bus.sel, bus.res_data, bus.res_sel, bus.res_pos});
    end
    // first cycle after reset falls must take start
    rst = 1'b0;
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.row_ready !== 1'b1) begin
      errors++; $display("FAIL reset_first_start: busy=%b ready=%b want 1 1", bus.busy, bus.row_ready);
    end
    bus.row_valid = 1'b1;
    begin
      bit ok; int mp;
      wait_idle(40, ok, mp);
      checks++;
      if (!ok) begin errors++; $display("FAIL reset_scan_timeout: busy=%b want 0", bus.busy); end
    end
  endtask

  task automatic test_basic();  // V1
    int b0 = cap_pos.size();
    int d0 = done_cnt;
    bit ok; int mp;
    rd_base = 5'h11; lr_en = 1'b0; bus.row_valid = 1'b1;
    start_scan(3'd2);
    bus.max_row = 3'd7;  // must not matter mid-scan
    wait_idle(40, ok, mp);
    checks++;
    if (!ok) begin errors++; $display("FAIL v1_timeout: busy=%b want 0", bus.busy); end
    checks++;
    if (cap_pos.size() - b0 != 3) begin
      errors++; $display("FAIL v1_count: got %0d want 3", cap_pos.size() - b0);
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (cap_data[b0+k] !== ((5'h11 + 5'(k)) ^ 5'h1F) || cap_sel[b0+k] !== {1'b1, 3'(k)} ||
            cap_pos[b0+k] !== 3'(k)) begin
          errors++; $display("FAIL v1_row%0d: got d=%h s=%h p=%0d want d=%h s=%h p=%0d", k,
                             cap_data[b0+k], cap_sel[b0+k], cap_pos[b0+k],
                             (5'h11 + 5'(k)) ^ 5'h1F, {1'b1, 3'(k)}, k);
        end
      end
      checks++;
      if (cap_cyc[b0+1] - cap_cyc[b0] != 2 || cap_cyc[b0+2] - cap_cyc[b0+1] != 2) begin
        errors++; $display("FAIL v1_spacing: got %0d,%0d want 2,2",
                           cap_cyc[b0+1] - cap_cyc[b0], cap_cyc[b0+2] - cap_cyc[b0+1]);
      end
      checks++;
      if (done_cnt - d0 != 1 || done_cyc != cap_cyc[b0+2]) begin
        errors++; $display("FAIL v1_done: got cnt=%0d cyc=%0d want cnt=1 cyc=%0d",
                           done_cnt - d0, done_cyc, cap_cyc[b0+2]);
      end
    end
    checks++;
    if (mp != 2) begin errors++; $display("FAIL v1_maxpos: got %0d want 2", mp); end
  endtask

  task automatic test_last_row();  // V2
    int b0 = cap_pos.size();
    int d0 = done_cnt;
    bit ok; int mp;
    rd_base = 5'h02; lr_en = 1'b1; lr_pos = 3'd3; bus.row_valid = 1'b1;
    start_scan(3'd7);
    wait_idle(60, ok, mp);
    lr_en = 1'b0;
    checks++;
    if (!ok || cap_pos.size() - b0 != 4 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL v2_count: got ok=%0d caps=%0d done=%0d want 1 4 1",
                         ok, cap_pos.size() - b0, done_cnt - d0);
    end else begin
      checks++;
      if (cap_pos[b0+3] !== 3'd3 || done_cyc != cap_cyc[b0+3]) begin
        errors++; $display("FAIL v2_lastpos: got %0d want 3", cap_pos[b0+3]);
      end
    end
    checks++;
    if (mp != 3) begin errors++; $display("FAIL v2_maxpos: got %0d want 3", mp); end
  endtask

  task automatic test_sel_wrap();  // V3
    int b0 = cap_pos.size();
    bit ok; int mp;
    logic [2:0] exp_sel [7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
    rd_base = 5'h00; lr_en = 1'b0; bus.row_valid = 1'b1;
    start_scan(3'd6);
    wait_idle(60, ok, mp);
    checks++;
    if (!ok || cap_pos.size() - b0 != 7) begin
      errors++; $display("FAIL v3_count: got ok=%0d caps=%0d want 1 7", ok, cap_pos.size() - b0);
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (cap_sel[b0+k] !== {1'b1, exp_sel[k]} || cap_pos[b0+k] !== 3'(k)) begin
          errors++; $display("FAIL v3_row%0d: got s=%h p=%0d want s=%h p=%0d", k,
                             cap_sel[b0+k], cap_pos[b0+k], {1'b1, exp_sel[k]}, k);
        end
      end
    end
    checks++;
    if (bad_sel != 0) begin errors++; $display("FAIL v3_sel_range: got %0d bad want 0", bad_sel); end
  endtask

  task automatic test_stall();  // V4
    int b0 = cap_pos.size();
    bit ok; int mp;
    logic [4:0] l0;
    rd_base = 5'h05; lr_en = 1'b0; bus.row_valid = 1'b0;
    start_scan(3'd1);
    l0 = bus.left_in2;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.row_ready !== 1'b1 || bus.left_in2 !== l0 || bus.pos_c !== 3'd0 ||
          bus.res_valid !== 1'b0) begin
        errors++; $display("FAIL v4_hold%0d: got rdy=%b l=%h p=%0d rv=%b want 1 %h 0 0", k,
                           bus.row_ready, bus.left_in2, bus.pos_c, bus.res_valid, l0);
      end
      tick();
    end
    bus.row_valid = 1'b1;
    tick();
    checks++;
    if (bus.left_in2 !== 5'h05 || bus.row_ready !== 1'b0) begin
      errors++; $display("FAIL v4_xfer: got l=%h rdy=%b want 05 0", bus.left_in2, bus.row_ready);
    end
    wait_idle(40, ok, mp);
    checks++;
    if (!ok || cap_pos.size() - b0 != 2) begin
      errors++; $display("FAIL v4_count: got ok=%0d caps=%0d want 1 2", ok, cap_pos.size() - b0);
    end else if (cap_data[b0] !== 5'h1A) begin
      errors++; $display("FAIL v4_data: got %h want 1a", cap_data[b0]);
    end
  endtask

  task automatic test_abort();  // V5
    int b0 = cap_pos.size();
    int d0 = done_cnt;
    bit ok, found; int mp;
    rd_base = 5'h08; lr_en = 1'b0; bus.row_valid = 1'b1;
    start_scan(3'd5);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1 && bus.row_ready === 1'b0 && bus.pos_c === 3'd1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    checks++;
    if (!found || bus.busy !== 1'b0 || bus.row_ready !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.done !== 1'b0) begin
      errors++; $display("FAIL v5_abort: got found=%0d busy=%b rdy=%b rv=%b done=%b want 1 0 0 0 0",
                         found, bus.busy, bus.row_ready, bus.res_valid, bus.done);
    end
    repeat (3) tick();
    checks++;
    if (cap_pos.size() - b0 != 1 || done_cnt != d0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL v5_after: got caps=%0d done=%0d busy=%b want 1 0 0",
                         cap_pos.size() - b0, done_cnt - d0, bus.busy);
    end
    b0 = cap_pos.size();
    start_scan(3'd1);
    checks++;
    if (bus.pos_c !== 3'd0 || bus.busy !== 1'b1) begin
      errors++; $display("FAIL v5_restart: got p=%0d busy=%b want 0 1", bus.pos_c, bus.busy);
    end
    wait_idle(40, ok, mp);
    checks++;
    if (!ok || cap_pos.size() - b0 != 2) begin
      errors++; $display("FAIL v5_rescan: got ok=%0d caps=%0d want 1 2", ok, cap_pos.size() - b0);
    end else if (cap_pos[b0] !== 3'd0 || cap_pos[b0+1] !== 3'd1) begin
      errors++; $display("FAIL v5_rescan_pos: got %0d,%0d want 0,1", cap_pos[b0], cap_pos[b0+1]);
    end
  endtask

  task automatic test_misc();  // one-row scan, start+abort in IDLE
    int b0 = cap_pos.size();
    bit ok; int mp;
    rd_base = 5'h0C; lr_en = 1'b0; bus.row_valid = 1'b1;
    start_scan(3'd0);
    wait_idle(20, ok, mp);
    checks++;
    if (!ok || cap_pos.size() - b0 != 1) begin
      errors++; $display("FAIL max0_count: got ok=%0d caps=%0d want 1 1", ok, cap_pos.size() - b0);
    end else if (cap_data[b0] !== 5'h13 || cap_pos[b0] !== 3'd0) begin
      errors++; $display("FAIL max0_data: got d=%h p=%0d want 13 0", cap_data[b0], cap_pos[b0]);
    end
    b0 = cap_pos.size();
    bus.abort = 1'b1;
    start_scan(3'd1);
    bus.abort = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL start_abort_idle: busy=%b want 1", bus.busy); end
    wait_idle(40, ok, mp);
    checks++;
    if (!ok || cap_pos.size() - b0 != 2) begin
      errors++; $display("FAIL start_abort_count: got ok=%0d caps=%0d want 1 2", ok, cap_pos.size() - b0);
    end
  endtask

  task automatic test_rst_mid();  // V6
    int b0 = cap_pos.size();
    bit found;
    rd_base = 5'h01; lr_en = 1'b0; bus.row_valid = 1'b1;
    start_scan(3'd7);
    for (int i = 0; i < 20; i++) begin
      if (bus.pos_c === 3'd2) break;
      tick();
    end
    bus.start = 1'b1;  // ignored while busy
    tick();
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.pos_c === 3'd4) begin found = 1'b1; break; end
      tick();
    end
    rst = 1'b1;
    bus.start = 1'b1;
    tick();
    checks++;
    if (!found || {bus.busy, bus.done, bus.res_valid, bus.row_ready} !== 4'b0000) begin
      errors++; $display("FAIL v6_flags: got found=%0d %b want 1 0000", found,
                         {bus.busy, bus.done, bus.res_valid, bus.row_ready});
    end
    checks++;
    if ({bus.left_in2, bus.pos_c, bus.sel, bus.res_data, bus.res_sel, bus.res_pos} !== 23'd0) begin
      errors++; $display("FAIL v6_regs: got %h want 0",
                         {bus.left_in2, bus.pos_c, bus.sel, bus.res_data, bus.res_sel, bus.res_pos});
    end
    checks++;
    if (cap_pos.size() - b0 != 4) begin
      errors++; $display("FAIL v6_rows: got %0d want 4", cap_pos.size() - b0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (cap_pos[b0+k] !== 3'(k)) begin
          errors++; $display("FAIL v6_pos%0d: got %0d want %0d", k, cap_pos[b0+k], k);
        end
      end
    end
    bus.start = 1'b0;
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL v6_idle: busy=%b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_last_row();
    test_sel_wrap();
    test_stall();
    test_abort();
    test_misc();
    test_rst_mid();
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
